dff_response_checker: RTL and testbench

//   Synthesizable self-check companion for the master-slave dff: the observing end of the
//   d/clk/clear stimulus interface. It shares clk/clear with the DUT, watches the d it is fed
//   and the q/qbar it returns, and confirms q tracks d with one-edge latency. Results are a

---
 rtl/dff_response_checker.sv | 127 ++++++++++++
 tb/tb_dff_response_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dff_response_checker.sv
// Observing end of the master-slave dff stimulus interface: checks q follows d with one-edge latency.
// Optional DFF_CHECK_QBAR_EN also requires qbar_mon to be the complement of q_mon on every check.
module dff_response_checker #(
    parameter int unsigned NUM_CHECKS = 16,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             d_mon,
    input  logic             q_mon,
    input  logic             qbar_mon,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHECKS - 1);
    localparam logic [CNT_W-1:0] NO_ERR   = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t           state, state_d;
    logic             busy_d, done_d, pass_d, err_pulse_d;
    logic [ERR_W-1:0] err_count_d;
    logic [CNT_W-1:0] first_err_d;
    logic [CNT_W-1:0] idx, idx_d;
    logic             d_prev, d_prev_d;
    logic             mismatch;

`ifndef DFF_CHECK_QBAR_EN
    logic unused_qbar;
    assign unused_qbar = qbar_mon;
`endif

    // State register and result registers
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            first_err <= NO_ERR;
            idx       <= '0;
            d_prev    <= 1'b0;
        end else begin
            state     <= state_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_pulse <= err_pulse_d;
            err_count <= err_count_d;
            first_err <= first_err_d;
            idx       <= idx_d;
            d_prev    <= d_prev_d;
        end
    end

    // Next-state and next-result logic
    always_comb begin
        state_d     = state;
        busy_d      = busy;
        done_d      = done;
        pass_d      = pass;
        err_pulse_d = 1'b0;
        err_count_d = err_count;
        first_err_d = first_err;
        idx_d       = idx;
        d_prev_d    = d_prev;
        mismatch    = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = ARM;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_count_d = '0;
                    first_err_d = NO_ERR;
                    idx_d       = '0;
                end
            end
            ARM: begin
                d_prev_d = d_mon;
                idx_d    = '0;
                state_d  = RUN;
            end
            RUN: begin
                // Case-inequality so an X/Z response is flagged in simulation
`ifdef DFF_CHECK_QBAR_EN
                mismatch = (q_mon !== d_prev) || (qbar_mon !== ~q_mon);
`else
                mismatch = (q_mon !== d_prev);
`endif
                d_prev_d = d_mon;
                idx_d    = idx + CNT_W'(1);
                if (mismatch) begin
                    err_pulse_d = 1'b1;
                    if (err_count != ERR_MAX) begin
                        err_count_d = err_count + ERR_W'(1);
                    end
                    if (first_err == NO_ERR) begin
                        first_err_d = idx;
                    end
                end
                if (idx == LAST_IDX) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == '0);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dff_response_checker.sv
// Scoreboard bench for dff_response_checker: an ideal dff model with injectable q/qbar faults,
// expected verdicts queued per run and popped by monitors when done rises.
module tb_dff_response_checker;

    typedef struct {
        int cnt;
        int fe;
        int pass;
        int pulses;
        int busy_cycles;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       d_mon = 1'b0;
    logic       q_ideal = 1'b0;
    logic       qinj = 1'b0;
    logic       binj = 1'b0;
    logic       q_mon, qbar_mon;

    logic       busy, done, pass, err_pulse;
    logic [7:0] err_count, first_err;
    logic       s_busy, s_done, s_pass, s_err_pulse;
    logic [1:0] s_err_count;
    logic [7:0] s_first_err;

    int passed = 0;
    int total  = 0;

    exp_t exp_q[$];
    exp_t sexp_q[$];

    logic [15:0] pat = 16'b1011_0010_0111_0100;

    always #5 clk = ~clk;

    // Ideal dff stands in for the device under observation
    always @(posedge clk) q_ideal <= d_mon;
    assign q_mon    = q_ideal ^ qinj;
    assign qbar_mon = ~q_mon ^ binj;

    dff_response_checker #(.NUM_CHECKS(16), .CNT_W(8), .ERR_W(8)) u_dut (
        .clk(clk), .clear(clear), .start(start), .d_mon(d_mon), .q_mon(q_mon),
        .qbar_mon(qbar_mon), .busy(busy), .done(done), .pass(pass),
        .err_pulse(err_pulse), .err_count(err_count), .first_err(first_err)
    );

    dff_response_checker #(.NUM_CHECKS(16), .CNT_W(8), .ERR_W(2)) u_sat (
        .clk(clk), .clear(clear), .start(start), .d_mon(d_mon), .q_mon(q_mon),
        .qbar_mon(qbar_mon), .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_pulse(s_err_pulse), .err_count(s_err_count), .first_err(s_first_err)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    // Monitors: count pulses/busy cycles, compare verdict when done rises
    int  pulse_cnt = 0, busy_cnt = 0, s_pulse_cnt = 0, s_busy_cnt = 0;
    logic done_q = 1'b0, s_done_q = 1'b0;

    always @(negedge clear) begin
        pulse_cnt = 0; busy_cnt = 0; s_pulse_cnt = 0; s_busy_cnt = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (err_pulse) pulse_cnt++;
        if (done && !done_q) begin
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("err_count", int'(err_count), e.cnt);
                chk("first_err", int'(first_err), e.fe);
                chk("pass", int'(pass), e.pass);
                chk("err_pulses", pulse_cnt, e.pulses);
                chk("busy_cycles", busy_cnt, e.busy_cycles);
            end
            pulse_cnt = 0; busy_cnt = 0;
        end
        done_q = done;
    end

    always @(negedge clk) begin
        exp_t e;
        if (s_busy) s_busy_cnt++;
        if (s_err_pulse) s_pulse_cnt++;
        if (s_done && !s_done_q) begin
            if (sexp_q.size() == 0) chk("sat_unexpected_done", 1, 0);
            else begin
                e = sexp_q.pop_front();
                chk("sat_err_count", int'(s_err_count), e.cnt);
                chk("sat_first_err", int'(s_first_err), e.fe);
                chk("sat_pass", int'(s_pass), e.pass);
                chk("sat_err_pulses", s_pulse_cnt, e.pulses);
            end
            s_pulse_cnt = 0; s_busy_cnt = 0;
        end
        s_done_q = s_done;
    end

    function automatic exp_t mk(input int c, input int f, input int p, input int n);
        exp_t e;
        e.cnt = c; e.fe = f; e.pass = p; e.pulses = n; e.busy_cycles = 17;
        return e;
    endfunction

    // One run: inject faults for check k during the cycle before edge E(2+k)
    task automatic run(input logic [15:0] qm, input logic [15:0] bm, input int abort_at,
                       input logic mid_start);
        @(negedge clk);
        start = 1'b1;
        d_mon = ~d_mon;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        d_mon = pat[0];
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            qinj  = qm[k];
            binj  = bm[k];
            d_mon = pat[(k + 1) % 16];
            start = (mid_start && k == 4) ? 1'b1 : 1'b0;
            if (k == abort_at) begin
                #2 clear = 1'b0;
                #1;
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_err_count", int'(err_count), 0);
                chk("abort_first_err", int'(first_err), 255);
                chk("abort_err_pulse", int'(err_pulse), 0);
                qinj = 1'b0;
                binj = 1'b0;
                @(negedge clk);
                clear = 1'b1;
                return;
            end
        end
        @(posedge clk);
        @(negedge clk);
        qinj = 1'b0;
        binj = 1'b0;
        for (int i = 0; i < 4 && !done; i++) @(negedge clk);
        chk("done_seen", int'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with start asserted
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err_pulse", int'(err_pulse), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_first_err", int'(first_err), 255);
        chk("rst_sat_first_err", int'(s_first_err), 255);
        start = 1'b0;
        clear = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);

        // Clean run, with a start pulse mid-run that must be ignored
        exp_q.push_back(mk(0, 255, 1, 0));
        sexp_q.push_back(mk(0, 255, 1, 0));
        run(16'h0000, 16'h0000, -1, 1'b1);

        // Faults at checks 5 and 9
        exp_q.push_back(mk(2, 5, 0, 2));
        sexp_q.push_back(mk(2, 5, 0, 2));
        run(16'h0220, 16'h0000, -1, 1'b0);
        chk("held_err_count", int'(err_count), 2);

        // Restart from DONE with clean response
        exp_q.push_back(mk(0, 255, 1, 0));
        sexp_q.push_back(mk(0, 255, 1, 0));
        run(16'h0000, 16'h0000, -1, 1'b0);

        // q stuck at ~d: every check fails, 2-bit counter saturates at 3
        exp_q.push_back(mk(16, 0, 0, 16));
        sexp_q.push_back(mk(3, 0, 0, 16));
        run(16'hFFFF, 16'h0000, -1, 1'b0);

        // Abort during check 7, then a full clean run
        run(16'h0000, 16'h0000, 7, 1'b0);
        exp_q.push_back(mk(0, 255, 1, 0));
        sexp_q.push_back(mk(0, 255, 1, 0));
        run(16'h0000, 16'h0000, -1, 1'b0);

        // qbar equals q at check 3 only
`ifdef DFF_CHECK_QBAR_EN
        exp_q.push_back(mk(1, 3, 0, 1));
        sexp_q.push_back(mk(1, 3, 0, 1));
`else
        exp_q.push_back(mk(0, 255, 1, 0));
        sexp_q.push_back(mk(0, 255, 1, 0));
`endif
        run(16'h0000, 16'h0008, -1, 1'b0);

        repeat (3) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("sexp_q_drained", sexp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
